// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RISC-V style datapath. It sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for each instruction and produces
// the memory, instruction-register, program-counter and register-file
// controls. A memory access that stays unacknowledged for MEM_TIMEOUT
// consecutive cycles, or an unsupported opcode, sends the FSM to TRAP.
// Only reset leaves TRAP.
//
// Parameters
//   MEM_TIMEOUT : maximum consecutive wait cycles in FETCH or MEM
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active low
//   opcode    in   instruction[6:0] from the instruction register
//   mem_ready in   memory acknowledges the current access
//   mem_req   out  memory access request
//   mem_we    out  current access is a write
//   ir_load   out  load the instruction register
//   pcEnable  out  advance the program counter
//   jalEnable out  PC update is a jump
//   branch    out  PC update is a conditional branch
//   reg_write out  register file write enable
//   wb_sel    out  write-back source: 00 ALU, 01 memory, 10 pc+4
//   state     out  current FSM state encoding
//   error     out  sticky trap flag
//   instret   out  retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_load,
   output logic        pcEnable,
   output logic        jalEnable,
   output logic        branch,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        error,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // The counter only ever needs to reach MEM_TIMEOUT-1.
   localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t            r_state;
   logic [6:0]        r_op_q;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [31:0]       r_instret;
   logic              r_error;

   state_t            w_next_state;
   logic              w_opcode_legal;
   logic              w_timeout;
   logic              w_is_store;
   logic              w_is_load;
   logic              w_is_jump;

   assign w_is_store = (r_op_q == OP_STORE);
   assign w_is_load  = (r_op_q == OP_LOAD);
   assign w_is_jump  = (r_op_q == OP_JAL) || (r_op_q == OP_JALR);

   // Legality is judged on the live opcode during DECODE, the same cycle it
   // is captured into r_op_q.
   assign w_opcode_legal = (opcode == OP_ALU)    || (opcode == OP_ALUI)  ||
                           (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                           (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                           (opcode == OP_JALR)   || (opcode == OP_LUI)   ||
                           (opcode == OP_AUIPC);

   // A ready on the final allowed wait cycle is not a timeout.
   assign w_timeout = !mem_ready && (r_wait_cnt == CNT_LAST);

   // Next-state selection.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_next_state = S_DECODE;
            else if (w_timeout) w_next_state = S_TRAP;
         end
         S_DECODE: w_next_state = w_opcode_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (r_op_q == OP_BRANCH)        w_next_state = S_FETCH;
            else if (w_is_load || w_is_store) w_next_state = S_MEM;
            else                              w_next_state = S_WB;
         end
         S_MEM: begin
            if (mem_ready)      w_next_state = w_is_store ? S_FETCH : S_WB;
            else if (w_timeout) w_next_state = S_TRAP;
         end
         S_WB:    w_next_state = S_FETCH;
         S_TRAP:  w_next_state = S_TRAP;
         default: w_next_state = S_TRAP;  // unused codes 5 and 6
      endcase
   end

   // Output decode. ir_load and the STORE pcEnable follow mem_ready in the
   // same cycle.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_load   = 1'b0;
      pcEnable  = 1'b0;
      jalEnable = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ready;
         end
         S_EXEC: begin
            if (r_op_q == OP_BRANCH) begin
               branch   = 1'b1;
               pcEnable = 1'b1;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = w_is_store;
            pcEnable = w_is_store && mem_ready;
         end
         S_WB: begin
            reg_write = 1'b1;
            pcEnable  = 1'b1;
            if (w_is_jump) begin
               jalEnable = 1'b1;
               wb_sel    = 2'b10;
            end else if (w_is_load) begin
               wb_sel    = 2'b01;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples values from before the edge.
      if (!rst) begin
         r_state    <= S_FETCH;
         r_op_q     <= '0;
         r_wait_cnt <= '0;
         r_instret  <= '0;
         r_error    <= 1'b0;
      end else begin
         r_state <= w_next_state;

         if (r_state == S_DECODE)
            r_op_q <= opcode;

         // Count only while waiting in place; any transition (including
         // entry to FETCH or MEM) starts the next access from zero.
         if (((r_state == S_FETCH) || (r_state == S_MEM)) && (w_next_state == r_state))
            r_wait_cnt <= r_wait_cnt + 1'b1;
         else
            r_wait_cnt <= '0;

         if (pcEnable)
            r_instret <= r_instret + 32'd1;

         if (w_next_state == S_TRAP)
            r_error <= 1'b1;
      end
   end

   assign state   = r_state;
   assign error   = r_error;
   assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. Each instruction is expanded by a
// behavioural model into the expected per-cycle trace (state, outputs, the
// mem_ready value to drive) from its instruction class and memory wait
// counts; the bench then steps the DUT through that trace and compares
// every cycle. instret is predicted by counting expected retire pulses.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int MEM_TIMEOUT = 16;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd7;

   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Output vector layout:
   // {mem_req, mem_we, ir_load, pcEnable, jalEnable, branch, reg_write, wb_sel[1:0], error}
   localparam logic [9:0] B_MREQ   = 10'b10_0000_0000;
   localparam logic [9:0] B_MWE    = 10'b01_0000_0000;
   localparam logic [9:0] B_IRL    = 10'b00_1000_0000;
   localparam logic [9:0] B_PC     = 10'b00_0100_0000;
   localparam logic [9:0] B_JAL    = 10'b00_0010_0000;
   localparam logic [9:0] B_BR     = 10'b00_0001_0000;
   localparam logic [9:0] B_RW     = 10'b00_0000_1000;
   localparam logic [9:0] B_WB_PC4 = 10'b00_0000_0100;
   localparam logic [9:0] B_WB_MEM = 10'b00_0000_0010;
   localparam logic [9:0] B_ERR    = 10'b00_0000_0001;

   typedef struct {
      logic       rdy;
      logic [2:0] st;
      logic [9:0] outs;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_load;
   logic        pcEnable;
   logic        jalEnable;
   logic        branch;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
   logic        error;
   logic [31:0] instret;

   logic [9:0]  w_outs;

   exp_t        exp_q[$];
   logic [6:0]  cur_op;
   logic [31:0] exp_instret;
   int          n_checks;
   int          n_fail;

   logic [6:0]  legal_ops[9];

   multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .ir_load   (ir_load),
      .pcEnable  (pcEnable),
      .jalEnable (jalEnable),
      .branch    (branch),
      .reg_write (reg_write),
      .wb_sel    (wb_sel),
      .state     (state),
      .error     (error),
      .instret   (instret)
   );

   assign w_outs = {mem_req, mem_we, ir_load, pcEnable, jalEnable, branch,
                    reg_write, wb_sel, error};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(input logic rdy, input logic [2:0] st, input logic [9:0] o);
      exp_t e;
      e.rdy  = rdy;
      e.st   = st;
      e.outs = o;
      exp_q.push_back(e);
   endfunction

   function automatic void push_trap();
      for (int i = 0; i < 3; i++) push(rbit(), ST_TRAP, B_ERR);
   endfunction

   function automatic bit op_is_legal(input logic [6:0] op);
      for (int i = 0; i < 9; i++)
         if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Expands one instruction into its expected cycle trace. fw/mw are the
   // number of not-ready cycles before memory acknowledges in FETCH/MEM.
   // Returns 1 when the instruction ends in TRAP.
   function automatic bit build(input logic [6:0] op, input int fw, input int mw);
      logic [9:0] we;
      logic [9:0] wb;
      bit         is_ld;
      bit         is_st;
      is_ld  = (op == OP_LOAD);
      is_st  = (op == OP_STORE);
      cur_op = op;
      for (int i = 0; i < fw && i < MEM_TIMEOUT; i++) push(1'b0, ST_FETCH, B_MREQ);
      if (fw >= MEM_TIMEOUT) begin
         push_trap();
         return 1'b1;
      end
      push(1'b1, ST_FETCH, B_MREQ | B_IRL);
      push(rbit(), ST_DECODE, 10'd0);
      if (!op_is_legal(op)) begin
         push_trap();
         return 1'b1;
      end
      if (op == OP_BRANCH) begin
         push(rbit(), ST_EXEC, B_BR | B_PC);
         return 1'b0;
      end
      push(rbit(), ST_EXEC, 10'd0);
      if (is_ld || is_st) begin
         we = is_st ? B_MWE : 10'd0;
         for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) push(1'b0, ST_MEM, B_MREQ | we);
         if (mw >= MEM_TIMEOUT) begin
            push_trap();
            return 1'b1;
         end
         push(1'b1, ST_MEM, B_MREQ | we | (is_st ? B_PC : 10'd0));
         if (is_st) return 1'b0;
      end
      wb = B_RW | B_PC;
      if (op == OP_JAL || op == OP_JALR) wb = wb | B_JAL | B_WB_PC4;
      else if (is_ld)                    wb = wb | B_WB_MEM;
      push(rbit(), ST_WB, wb);
      return 1'b0;
   endfunction

   // ---------------------------------------------------------------- driver
   // Steps the DUT through queued expectations (all of them when limit < 0).
   // Entered and left at a falling edge.
   task automatic run_trace(input string name, input int limit);
      int n;
      n = 0;
      while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
         exp_t it;
         it = exp_q.pop_front();
         mem_ready = it.rdy;
         // Outside DECODE the opcode input is noise; the FSM must use op_q.
         opcode = (it.st == ST_DECODE) ? cur_op : 7'($urandom);
         #1;
         n_checks++;
         if (state !== it.st) begin
            n_fail++;
            $display("FAIL %s cycle %0d state: got %0d expected %0d", name, n, state, it.st);
         end
         n_checks++;
         if (w_outs !== it.outs) begin
            n_fail++;
            $display("FAIL %s cycle %0d outputs: got %b expected %b", name, n, w_outs, it.outs);
         end
         n_checks++;
         if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL %s cycle %0d instret: got %0d expected %0d", name, n, instret, exp_instret);
         end
         if (it.outs[6]) exp_instret = exp_instret + 32'd1;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      rst         = 1'b1;
      exp_instret = 32'd0;
      exp_q.delete();
   endtask

   task automatic check_idle(input string name, input logic [31:0] exp_cnt);
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (state !== ST_FETCH || w_outs !== B_MREQ || instret !== exp_cnt) begin
         n_fail++;
         $display("FAIL %s idle: got state %0d outs %b instret %0d expected state 0 outs %b instret %0d",
                  name, state, w_outs, instret, B_MREQ, exp_cnt);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst       = 1'b0;
      mem_ready = 1'b0;
      opcode    = 7'($urandom);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (state !== ST_FETCH) begin
         n_fail++;
         $display("FAIL reset state: got %0d expected 0", state);
      end
      n_checks++;
      if (w_outs !== B_MREQ) begin
         n_fail++;
         $display("FAIL reset outputs: got %b expected %b", w_outs, B_MREQ);
      end
      n_checks++;
      if (instret !== 32'd0) begin
         n_fail++;
         $display("FAIL reset instret: got %0d expected 0", instret);
      end
      // A ready seen while reset is held must not advance the FSM.
      mem_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (state !== ST_FETCH) begin
         n_fail++;
         $display("FAIL reset_hold state: got %0d expected 0", state);
      end
      mem_ready   = 1'b0;
      rst         = 1'b1;
      exp_instret = 32'd0;
   endtask

   task automatic test_add();
      do_reset();
      void'(build(OP_ALU, 0, 0));
      run_trace("add", -1);
      check_idle("add_done", 32'd1);
   endtask

   task automatic test_load_delay();
      do_reset();
      void'(build(OP_LOAD, 0, 3));
      run_trace("load_wait3", -1);
      check_idle("load_done", 32'd1);
   endtask

   task automatic test_branch_jumps();
      do_reset();
      void'(build(OP_BRANCH, 0, 0));
      run_trace("branch", -1);
      void'(build(OP_JAL, 2, 0));
      run_trace("jal", -1);
      void'(build(OP_JALR, 0, 0));
      run_trace("jalr", -1);
      void'(build(OP_STORE, 1, 2));
      run_trace("store", -1);
      check_idle("jumps_done", 32'd4);
   endtask

   task automatic test_timeout();
      do_reset();
      void'(build(OP_ALU, MEM_TIMEOUT, 0));
      run_trace("fetch_timeout", -1);
      do_reset();
      void'(build(OP_ALU, MEM_TIMEOUT - 1, 0));
      run_trace("fetch_ready_last", -1);
      do_reset();
      void'(build(OP_STORE, 0, MEM_TIMEOUT));
      run_trace("mem_timeout", -1);
      do_reset();
      void'(build(OP_LOAD, 0, MEM_TIMEOUT - 1));
      run_trace("mem_ready_last", -1);
   endtask

   task automatic test_illegal();
      do_reset();
      void'(build(7'b1111111, 0, 0));
      run_trace("illegal_op", -1);
   endtask

   task automatic test_reset_mid_store();
      do_reset();
      void'(build(OP_ALU, 0, 0));
      run_trace("pre_store_add", -1);
      void'(build(OP_STORE, 0, 5));
      // FETCH, DECODE, EXEC, two MEM waits: leaves the DUT in MEM with mem_we=1.
      run_trace("store_partial", 5);
      rst       = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (state !== ST_MEM || mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL store_abort_pre: got state %0d mem_we %b expected state 3 mem_we 1", state, mem_we);
      end
      @(negedge clk);
      n_checks++;
      if (state !== ST_FETCH || w_outs !== B_MREQ || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL store_abort: got state %0d outs %b instret %0d expected state 0 outs %b instret 0",
                  state, w_outs, instret, B_MREQ);
      end
      rst         = 1'b1;
      exp_instret = 32'd0;
      exp_q.delete();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 60; k++) begin
         logic [6:0] op;
         int         fw;
         int         mw;
         bit         trapped;
         if ($urandom_range(0, 9) == 0) op = 7'($urandom);
         else                           op = legal_ops[$urandom_range(0, 8)];
         fw = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT : int'($urandom_range(0, 4));
         mw = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT : int'($urandom_range(0, 4));
         trapped = build(op, fw, mw);
         run_trace("random", -1);
         if (trapped) do_reset();
      end
   endtask

   initial begin
      legal_ops = '{OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      n_checks    = 0;
      n_fail      = 0;
      exp_instret = 32'd0;
      rst         = 1'b0;
      mem_ready   = 1'b0;
      opcode      = 7'd0;
      test_reset();
      test_add();
      test_load_delay();
      test_branch_jumps();
      test_timeout();
      test_illegal();
      test_reset_mid_store();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net so the run always ends even if the stimulus stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of consecutive wait cycles allowed in FETCH or MEM while mem_ready=0.
REQ-002 The block SHALL have port clk input 1: the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst input 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port opcode input 7: instruction[6:0] from the instruction register.
REQ-005 The block SHALL have port mem_ready input 1: memory acknowledges the current access.
REQ-006 The block SHALL have port mem_req output 1: memory access request.
REQ-007 The block SHALL have port mem_we output 1: the current access is a write.
REQ-008 The block SHALL have port ir_load output 1: load the instruction register.
REQ-009 The block SHALL have ports pcEnable, jalEnable and branch, each output 1, driving the program-counter update controls.
REQ-010 The block SHALL have port reg_write output 1: register file write enable.
REQ-011 The block SHALL have port wb_sel output 2: write-back source; 00=ALU, 01=memory, 10=pc+4.
REQ-012 The block SHALL have port state output 3: current FSM state encoding.
REQ-013 The block SHALL have port error output 1: sticky trap flag.
REQ-014 The block SHALL have port instret output 32: retired-instruction count.

Function
REQ-015 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=7; codes 5 and 6 SHALL go to TRAP on the next edge.
REQ-016 FETCH: the block SHALL drive mem_req=1 and mem_we=0, and hold FETCH until mem_ready=1.
REQ-017 FETCH: ir_load SHALL equal mem_ready (Mealy), and the next state SHALL be DECODE on the cycle mem_ready=1.
REQ-018 DECODE: the block SHALL last 1 cycle and capture opcode into internal register op_q.
REQ-019 DECODE: opcodes other than 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 and 0010111 SHALL go to TRAP; all others SHALL go to EXEC.
REQ-020 EXEC: the block SHALL last 1 cycle.
REQ-021 EXEC with op_q=BRANCH: branch=1 and pcEnable=1, next state FETCH.
REQ-022 EXEC with op_q=LOAD or STORE: next state MEM.
REQ-023 EXEC with any other op_q: next state WB.
REQ-024 MEM: mem_req=1, and mem_we=1 only when op_q=STORE; the block SHALL hold MEM until mem_ready=1.
REQ-025 MEM on mem_ready=1 with op_q=LOAD: next state WB.
REQ-026 MEM on mem_ready=1 with op_q=STORE: pcEnable=1 in that cycle, next state FETCH.
REQ-027 WB: 1 cycle with reg_write=1 and pcEnable=1; next state FETCH.
REQ-028 WB: jalEnable=1 and wb_sel=10 for JAL/JALR; wb_sel=01 for LOAD; otherwise wb_sel=00.
REQ-029 Outputs not named for a state SHALL be 0 in that state.
REQ-030 Wait counter: reset to 0 on entry to FETCH or MEM; incremented each cycle in those states with mem_ready=0.
REQ-031 When mem_ready=0 and the wait counter equals MEM_TIMEOUT-1, the next state SHALL be TRAP.
REQ-032 mem_ready=1 in the same cycle as the REQ-031 condition SHALL win: normal transition, no trap.
REQ-033 TRAP: all enables and mem_req SHALL be 0 and error=1; TRAP SHALL be left only by reset.
REQ-034 instret SHALL increment by 1 in every cycle pcEnable=1, wrapping from FFFFFFFF to 0.
REQ-035 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-036 Latency: BRANCH 3 cycles, STORE 4, ALU/JAL/JALR/LUI/AUIPC 4, LOAD 5, plus memory wait cycles in each case.

Reset
REQ-037 With rst=0 at a rising edge: state=FETCH, op_q=0, wait counter=0, instret=0, error=0; all outputs SHALL be 0 except mem_req=1, which follows from FETCH.
REQ-038 Reset SHALL abort any state, including MEM with mem_we=1 and TRAP, on that edge.

Verification
REQ-039 ADD 0110011 with mem_ready=1 every fetch -> states 0,1,2,4; reg_write, pcEnable=1 in WB; instret=1 after 4 cycles.
REQ-040 LOAD with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, wb_sel=01 in WB, 5+3 cycles total.
REQ-041 BRANCH 1100011 -> branch=1 and pcEnable=1 in EXEC, back to FETCH after 3 cycles, reg_write never 1.
REQ-042 JAL 1101111 -> jalEnable=1, wb_sel=10 in WB.
REQ-043 mem_ready=0 for 16 FETCH cycles (MEM_TIMEOUT=16) -> TRAP, error=1; a ready on the 16th wait cycle -> DECODE with no trap.
REQ-044 Opcode 1111111 -> TRAP after DECODE; rst=0 mid-MEM STORE -> FETCH next edge, instret=0.
